// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared definitions for the UART receive controller:
//   state_t      - receiver FSM state encoding
//   PAR_EVEN/ODD - parity type selector values
//   MIN_DATA_LEN - shortest data field accepted
//   clamp_len()  - folds a requested data length into the supported range
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP1    = 3'd4,
    STOP2    = 3'd5,
    DONE     = 3'd6,
    BRK_WAIT = 3'd7
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int MIN_DATA_LEN = 5;

  // Requests shorter than the minimum are widened, requests wider than the
  // data register are narrowed, so a frame can never index past P_DATA.
  function automatic logic [3:0] clamp_len(input logic [3:0] len,
                                           input logic [3:0] max_len);
    if (len < 4'(MIN_DATA_LEN))
      return 4'(MIN_DATA_LEN);
    else if (len > max_len)
      return max_len;
    else
      return len;
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// uart_rx_bit_sampler
// Oversampling edge counter plus 2-of-3 majority vote for one serial bit.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - holds the edge counter at 0 while no frame is running
//   prescale  - oversampling ratio of the current frame (even, >= 6)
//   rx        - serial line
//   bit_val   - voted bit value, meaningful while decide is high
//   decide    - high in the cycle the vote is taken (edge count mid+1)
//   boundary  - high in the last cycle of a bit (edge count prescale-1)
module uart_rx_bit_sampler #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      rx,
  output logic                      bit_val,
  output logic                      decide,
  output logic                      boundary
);

  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] mid;
  logic [PRESCALE_WIDTH-1:0] last_cnt;
  logic                      samp_a;
  logic                      samp_b;

  assign mid      = prescale >> 1;
  assign last_cnt = prescale - PRESCALE_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst || clear)
      edge_cnt <= '0;
    else if (edge_cnt == last_cnt)
      edge_cnt <= '0;
    else
      edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
  end

  // The first two votes are stored; the third is the live line value in the
  // deciding cycle, so the decision costs no extra cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_a <= 1'b0;
      samp_b <= 1'b0;
    end else begin
      if (edge_cnt == mid - PRESCALE_WIDTH'(1))
        samp_a <= rx;
      if (edge_cnt == mid)
        samp_b <= rx;
    end
  end

  assign bit_val  = (samp_a & samp_b) | (samp_a & rx) | (samp_b & rx);
  assign decide   = !clear && (edge_cnt == mid + PRESCALE_WIDTH'(1));
  assign boundary = !clear && (edge_cnt == last_cnt);

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// UART receiver with configurable data length, optional parity, one or two
// stop bits, start-glitch rejection and break detection.
// Ports:
//   CLK, RST      - clock, synchronous active-high reset
//   RX_IN         - serial line, idle high
//   Prescale      - oversampling ratio (even, >= 6)
//   Data_Len      - data bits per frame, clamped to 5..MAX_WIDTH
//   PAR_EN        - parity bit present
//   PAR_TYP       - 0 even, 1 odd parity
//   Stop2         - two stop bits
//   P_DATA        - received word, right-aligned, held until the next frame
//   Data_Valid    - one-cycle pulse, frame received without error
//   Par_Err       - one-cycle pulse, parity mismatch
//   Stp_Err       - one-cycle pulse, a stop bit was 0 (also on break)
//   Strt_Glitch   - one-cycle pulse, start bit did not hold low
//   Brk_Det       - one-cycle pulse, whole frame was low
//   Busy          - receiver is not idle
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int MAX_WIDTH      = 9,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [3:0]                Data_Len,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      Stop2,
  output logic [MAX_WIDTH-1:0]      P_DATA,
  output logic                      Data_Valid,
  output logic                      Par_Err,
  output logic                      Stp_Err,
  output logic                      Strt_Glitch,
  output logic                      Brk_Det,
  output logic                      Busy
);

  state_t                    state;
  state_t                    next_state;

  logic [PRESCALE_WIDTH-1:0] prescale_r;
  logic [3:0]                len_r;
  logic                      par_en_r;
  logic                      par_typ_r;
  logic                      stop2_r;

  logic [3:0]                bit_idx;
  logic [3:0]                last_idx;
  logic                      par_acc;
  logic                      par_err_r;
  logic                      stp_err_r;
  logic                      all_zero_r;
  logic [MAX_WIDTH-1:0]      p_data;

  logic                      start_det;
  logic                      sampler_clear;
  logic                      bit_val;
  logic                      decide;
  logic                      boundary;

  assign start_det     = (state == IDLE) && !RX_IN;
  assign last_idx      = len_r - 4'd1;
  // Only bit-timed states run the edge counter; everywhere else it sits at 0
  // so the first cycle after start detection is edge count 0.
  assign sampler_clear = (state == IDLE) || (state == DONE) || (state == BRK_WAIT);

  uart_rx_bit_sampler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_sampler (
    .clk      (CLK),
    .rst      (RST),
    .clear    (sampler_clear),
    .prescale (prescale_r),
    .rx       (RX_IN),
    .bit_val  (bit_val),
    .decide   (decide),
    .boundary (boundary)
  );

  always_ff @(posedge CLK) begin
    if (RST)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Stop bits leave on their decision rather than the bit boundary, which
  // leaves half a bit of slack to catch a start bit that follows directly.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (!RX_IN) next_state = START;
      START: begin
        if (decide && bit_val) next_state = IDLE;
        else if (boundary)     next_state = DATA;
      end
      DATA:     if (boundary && (bit_idx == last_idx))
                  next_state = par_en_r ? PARITY : STOP1;
      PARITY:   if (boundary) next_state = STOP1;
      STOP1: begin
        if (decide && !stop2_r)     next_state = DONE;
        else if (boundary && stop2_r) next_state = STOP2;
      end
      STOP2:    if (decide) next_state = DONE;
      DONE:     next_state = all_zero_r ? BRK_WAIT : IDLE;
      BRK_WAIT: if (RX_IN) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Frame configuration is frozen at start detection; per-frame status
  // flags are re-armed at the same moment. all_zero_r starts set because
  // reaching DATA at all implies the start bit voted 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prescale_r <= '0;
      len_r      <= '0;
      par_en_r   <= 1'b0;
      par_typ_r  <= PAR_EVEN;
      stop2_r    <= 1'b0;
      bit_idx    <= '0;
      par_acc    <= 1'b0;
      par_err_r  <= 1'b0;
      stp_err_r  <= 1'b0;
      all_zero_r <= 1'b0;
      p_data     <= '0;
    end else begin
      if (start_det) begin
        prescale_r <= Prescale;
        len_r      <= clamp_len(Data_Len, 4'(MAX_WIDTH));
        par_en_r   <= PAR_EN;
        par_typ_r  <= PAR_TYP ? PAR_ODD : PAR_EVEN;
        stop2_r    <= Stop2;
        bit_idx    <= '0;
        par_err_r  <= 1'b0;
        stp_err_r  <= 1'b0;
        all_zero_r <= 1'b1;
      end

      if (decide && bit_val)
        all_zero_r <= 1'b0;

      case (state)
        DATA: begin
          // The first data bit wipes the previous word, so bits above the
          // frame length read as 0 and the old word stays visible until then.
          if (decide) begin
            p_data  <= ((bit_idx == 4'd0) ? '0 : p_data) |
                       (MAX_WIDTH'(bit_val) << bit_idx);
            par_acc <= (bit_idx == 4'd0) ? bit_val : (par_acc ^ bit_val);
          end
          if (boundary)
            bit_idx <= (bit_idx == last_idx) ? 4'd0 : bit_idx + 4'd1;
        end
        PARITY: begin
          if (decide)
            par_err_r <= (bit_val != (par_acc ^ par_typ_r));
        end
        STOP1, STOP2: begin
          if (decide && !bit_val)
            stp_err_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Data_Valid  = 1'b0;
    Par_Err     = 1'b0;
    Stp_Err     = 1'b0;
    Strt_Glitch = 1'b0;
    Brk_Det     = 1'b0;
    case (state)
      START: Strt_Glitch = decide && bit_val;
      DONE: begin
        Par_Err    = par_err_r;
        Stp_Err    = stp_err_r || all_zero_r;
        Brk_Det    = all_zero_r;
        Data_Valid = !par_err_r && !stp_err_r && !all_zero_r;
      end
      default: ;
    endcase
  end

  assign Busy   = (state != IDLE);
  assign P_DATA = p_data;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
// Directed bench for uart_rx_ctrl. Inputs change 1 time unit after a rising
// edge and outputs are read at the same point or on the falling edge.
// Cycle numbering: a frame's T0 is the cycle in which RX_IN first reads 0.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic [3:0] Data_Len = 4'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       Stop2 = 1'b0;

  logic [8:0] P_DATA;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stp_Err;
  logic       Strt_Glitch;
  logic       Brk_Det;
  logic       Busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Pulse tallies gathered on the falling edge.
  int         dv_total = 0;
  int         pe_total = 0;
  int         se_total = 0;
  int         gl_total = 0;
  int         bk_total = 0;
  int         dv_last_cyc = 0;
  int         gl_last_cyc = 0;
  logic [8:0] dv_last_data = '0;

  int b_dv, b_pe, b_se, b_gl, b_bk;

  uart_rx_ctrl #(
    .MAX_WIDTH      (9),
    .PRESCALE_WIDTH (6)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .Data_Len    (Data_Len),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .Stop2       (Stop2),
    .P_DATA      (P_DATA),
    .Data_Valid  (Data_Valid),
    .Par_Err     (Par_Err),
    .Stp_Err     (Stp_Err),
    .Strt_Glitch (Strt_Glitch),
    .Brk_Det     (Brk_Det),
    .Busy        (Busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (Data_Valid) begin
      dv_total     <= dv_total + 1;
      dv_last_cyc  <= cyc;
      dv_last_data <= P_DATA;
    end
    if (Par_Err) pe_total <= pe_total + 1;
    if (Stp_Err) se_total <= se_total + 1;
    if (Brk_Det) bk_total <= bk_total + 1;
    if (Strt_Glitch) begin
      gl_total    <= gl_total + 1;
      gl_last_cyc <= cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic snapshot();
    b_dv = dv_total;
    b_pe = pe_total;
    b_se = se_total;
    b_gl = gl_total;
    b_bk = bk_total;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setConfig(input logic [5:0] p, input logic [3:0] len,
                           input logic pen, input logic ptyp, input logic s2);
    Prescale = p;
    Data_Len = len;
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    Stop2    = s2;
  endtask

  // Drives one frame bit by bit; first stop bit is always 1 and lasts
  // stop_cycles, the optional second stop bit carries stop_b.
  task automatic applyStimulus(input logic [8:0] data, input int nbits,
                               input logic with_par, input logic par_bit,
                               input logic two_stops, input logic stop_b,
                               input int stop_cycles, output int t0);
    int p;
    p = int'(Prescale);
    RX_IN = 1'b0;
    t0 = cyc;
    tick(p);
    for (int i = 0; i < nbits; i++) begin
      RX_IN = data[i];
      tick(p);
    end
    if (with_par) begin
      RX_IN = par_bit;
      tick(p);
    end
    RX_IN = 1'b1;
    tick(stop_cycles);
    if (two_stops) begin
      RX_IN = stop_b;
      tick(p);
    end
    RX_IN = 1'b1;
  endtask

  initial begin
    int t0;
    int t1;

    // Reset state
    RST = 1'b1;
    tick(3);
    checkOutput("reset_busy", 32'(Busy), 32'd0);
    checkOutput("reset_pdata", 32'(P_DATA), 32'h000);
    checkOutput("reset_flags", 32'({Data_Valid, Par_Err, Stp_Err, Strt_Glitch, Brk_Det}), 32'd0);
    RST = 1'b0;
    tick(2);

    // 0xA5, 8N1, Prescale 8: stop bit votes in T0+78, DONE in T0+79
    $display("[TB] frame 0xA5 8N1");
    setConfig(6'd8, 4'd8, 1'b0, 1'b0, 1'b0);
    snapshot();
    applyStimulus(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8, t0);
    tick(4);
    checkOutput("a5_dv_count", 32'(dv_total - b_dv), 32'd1);
    checkOutput("a5_dv_cycle", 32'(dv_last_cyc - t0), 32'd79);
    checkOutput("a5_dv_data", 32'(dv_last_data), 32'h0A5);
    checkOutput("a5_no_errs", 32'((pe_total - b_pe) + (se_total - b_se) + (gl_total - b_gl) + (bk_total - b_bk)), 32'd0);
    checkOutput("a5_idle_busy", 32'(Busy), 32'd0);
    checkOutput("a5_hold", 32'(P_DATA), 32'h0A5);

    // Data_Len 5, 0x1F: old upper bits of 0xA5 must be cleared; DONE at T0+55
    $display("[TB] frame 0x1F 5N1");
    setConfig(6'd8, 4'd5, 1'b0, 1'b0, 1'b0);
    snapshot();
    applyStimulus(9'h01F, 5, 1'b0, 1'b0, 1'b0, 1'b1, 8, t0);
    tick(4);
    checkOutput("len5_dv_count", 32'(dv_total - b_dv), 32'd1);
    checkOutput("len5_dv_cycle", 32'(dv_last_cyc - t0), 32'd55);
    checkOutput("len5_pdata", 32'(P_DATA), 32'h01F);

    // Data_Len 15 folds to 9 bits
    $display("[TB] frame 0x155 with Data_Len 15");
    setConfig(6'd8, 4'd15, 1'b0, 1'b0, 1'b0);
    snapshot();
    applyStimulus(9'h155, 9, 1'b0, 1'b0, 1'b0, 1'b1, 8, t0);
    tick(4);
    checkOutput("clamp_dv_count", 32'(dv_total - b_dv), 32'd1);
    checkOutput("clamp_pdata", 32'(P_DATA), 32'h155);

    // 0x3C has four ones; odd parity expects a parity bit of 1
    $display("[TB] frame 0x3C 8O1 Prescale 16");
    setConfig(6'd16, 4'd8, 1'b1, 1'b1, 1'b0);
    snapshot();
    applyStimulus(9'h03C, 8, 1'b1, 1'b0, 1'b0, 1'b1, 16, t0);
    tick(4);
    checkOutput("par_bad_pe", 32'(pe_total - b_pe), 32'd1);
    checkOutput("par_bad_dv", 32'(dv_total - b_dv), 32'd0);
    checkOutput("par_bad_se", 32'(se_total - b_se), 32'd0);
    snapshot();
    applyStimulus(9'h03C, 8, 1'b1, 1'b1, 1'b0, 1'b1, 16, t0);
    tick(4);
    checkOutput("par_good_pe", 32'(pe_total - b_pe), 32'd0);
    checkOutput("par_good_dv", 32'(dv_total - b_dv), 32'd1);
    checkOutput("par_good_data", 32'(dv_last_data), 32'h03C);

    // Start glitch: low two cycles, vote in T0+6 sees high
    $display("[TB] start glitch");
    setConfig(6'd8, 4'd8, 1'b0, 1'b0, 1'b0);
    snapshot();
    RX_IN = 1'b0;
    t0 = cyc;
    tick(1);
    checkOutput("glitch_busy_t1", 32'(Busy), 32'd1);
    tick(1);
    RX_IN = 1'b1;
    tick(6);
    checkOutput("glitch_busy_t8", 32'(Busy), 32'd0);
    tick(4);
    checkOutput("glitch_count", 32'(gl_total - b_gl), 32'd1);
    checkOutput("glitch_cycle", 32'(gl_last_cyc - t0), 32'd6);
    checkOutput("glitch_no_dv", 32'(dv_total - b_dv), 32'd0);

    // Two stop bits, second one driven 0
    $display("[TB] frame 0x55 8N2 bad second stop");
    setConfig(6'd8, 4'd8, 1'b0, 1'b0, 1'b1);
    snapshot();
    applyStimulus(9'h055, 8, 1'b0, 1'b0, 1'b1, 1'b0, 8, t0);
    tick(4);
    checkOutput("stop2_se", 32'(se_total - b_se), 32'd1);
    checkOutput("stop2_dv", 32'(dv_total - b_dv), 32'd0);
    checkOutput("stop2_bk", 32'(bk_total - b_bk), 32'd0);
    checkOutput("stop2_pdata", 32'(P_DATA), 32'h055);

    // Reset in the middle of a frame, then a clean frame
    $display("[TB] reset mid-frame");
    setConfig(6'd8, 4'd8, 1'b0, 1'b0, 1'b0);
    snapshot();
    RX_IN = 1'b0;
    tick(8);
    RX_IN = 1'b0;
    tick(8);
    RX_IN = 1'b1;
    tick(8);
    RST = 1'b1;
    tick(1);
    checkOutput("midrst_busy", 32'(Busy), 32'd0);
    checkOutput("midrst_pdata", 32'(P_DATA), 32'h000);
    checkOutput("midrst_flags", 32'({Data_Valid, Par_Err, Stp_Err, Strt_Glitch, Brk_Det}), 32'd0);
    RST = 1'b0;
    tick(20);
    checkOutput("midrst_no_pulses", 32'((dv_total - b_dv) + (pe_total - b_pe) + (se_total - b_se) + (bk_total - b_bk)), 32'd0);
    snapshot();
    applyStimulus(9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8, t0);
    tick(4);
    checkOutput("after_rst_dv", 32'(dv_total - b_dv), 32'd1);
    checkOutput("after_rst_data", 32'(P_DATA), 32'h0C3);

    // Back-to-back frames: next start bit begins 6 cycles into the stop bit
    $display("[TB] back-to-back frames");
    snapshot();
    applyStimulus(9'h096, 8, 1'b0, 1'b0, 1'b0, 1'b1, 6, t0);
    applyStimulus(9'h069, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8, t1);
    tick(4);
    checkOutput("b2b_dv_count", 32'(dv_total - b_dv), 32'd2);
    checkOutput("b2b_last_data", 32'(dv_last_data), 32'h069);
    checkOutput("b2b_no_glitch", 32'(gl_total - b_gl), 32'd0);

    // Break: 12 bit-times low with 8E1; DONE at T0+87, then BRK_WAIT
    $display("[TB] break");
    setConfig(6'd8, 4'd8, 1'b1, 1'b0, 1'b0);
    snapshot();
    RX_IN = 1'b0;
    t0 = cyc;
    tick(95);
    checkOutput("brk_busy_low", 32'(Busy), 32'd1);
    checkOutput("brk_count", 32'(bk_total - b_bk), 32'd1);
    checkOutput("brk_se", 32'(se_total - b_se), 32'd1);
    checkOutput("brk_no_dv", 32'(dv_total - b_dv), 32'd0);
    checkOutput("brk_no_pe", 32'(pe_total - b_pe), 32'd0);
    tick(1);
    RX_IN = 1'b1;
    checkOutput("brk_busy_rise", 32'(Busy), 32'd1);
    tick(1);
    checkOutput("brk_busy_idle", 32'(Busy), 32'd0);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
